// File: rtl/off_mode_toggle_controller.sv
// Power-key confirmation controller for leaving OFF mode: the first press arms the
// OFF-mode event timer, and a second press inside the window requests STANDBY.
module off_mode_toggle_controller #(
    parameter int MODE_WIDTH   = 3,
    parameter int MAX_WIDTH    = 16,
    parameter int OFF_CODE     = 0,
    parameter int STANDBY_CODE = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  key_in,
    input  logic [MODE_WIDTH-1:0] current_mode,
    input  logic [MAX_WIDTH-1:0]  window_time,
    input  logic [MAX_WIDTH-1:0]  off_output_time,
    output logic                  first_toggle_signal,
    output logic [MAX_WIDTH-1:0]  counter_time,
    output logic                  mode_req_valid,
    output logic [MODE_WIDTH-1:0] mode_req,
    input  logic                  mode_req_ready,
    output logic                  timeout_pulse
);

    localparam logic [MODE_WIDTH-1:0] OFF_MODE     = MODE_WIDTH'(OFF_CODE);
    localparam logic [MODE_WIDTH-1:0] STANDBY_MODE = MODE_WIDTH'(STANDBY_CODE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        WINDOW = 2'd2,
        REQ    = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    load_cnt;
    logic                    load_cnt_nxt;
    logic                    key_prev;
    logic                    press;
    logic                    mode_is_off;
    logic                    first_toggle_nxt;
    logic [MAX_WIDTH-1:0]    counter_time_nxt;
    logic                    mode_req_valid_nxt;
    logic [MODE_WIDTH-1:0]   mode_req_nxt;
    logic                    timeout_pulse_nxt;

    // Key history resets high so a key held through reset is never seen as a press.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_prev <= 1'b1;
        end else begin
            key_prev <= key_in;
        end
    end

    assign press       = key_in & ~key_prev;
    assign mode_is_off = (current_mode == OFF_MODE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state               <= IDLE;
            load_cnt            <= 1'b0;
            first_toggle_signal <= 1'b0;
            counter_time        <= '0;
            mode_req_valid      <= 1'b0;
            mode_req            <= OFF_MODE;
            timeout_pulse       <= 1'b0;
        end else begin
            state               <= state_nxt;
            load_cnt            <= load_cnt_nxt;
            first_toggle_signal <= first_toggle_nxt;
            counter_time        <= counter_time_nxt;
            mode_req_valid      <= mode_req_valid_nxt;
            mode_req            <= mode_req_nxt;
            timeout_pulse       <= timeout_pulse_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        load_cnt_nxt       = load_cnt;
        first_toggle_nxt   = 1'b0;
        timeout_pulse_nxt  = 1'b0;
        counter_time_nxt   = counter_time;
        mode_req_valid_nxt = mode_req_valid;
        mode_req_nxt       = mode_req;

        case (state)
            IDLE: begin
                load_cnt_nxt = 1'b0;
                if (press && mode_is_off && (window_time != '0)) begin
                    counter_time_nxt = window_time;
                    first_toggle_nxt = 1'b1;
                    state_nxt        = LOAD;
                end
            end

            // Two cycles let the timer see its reset release and then its load value.
            LOAD: begin
                if (!mode_is_off) begin
                    state_nxt = IDLE;
                end else if (load_cnt) begin
                    state_nxt = WINDOW;
                end else begin
                    load_cnt_nxt = 1'b1;
                end
            end

            // Expiry is checked before the press so a coincident press still times out.
            WINDOW: begin
                if (!mode_is_off) begin
                    state_nxt = IDLE;
                end else if (off_output_time == '0) begin
                    timeout_pulse_nxt = 1'b1;
                    state_nxt         = IDLE;
                end else if (press) begin
                    mode_req_valid_nxt = 1'b1;
                    mode_req_nxt       = STANDBY_MODE;
                    state_nxt          = REQ;
                end
            end

            REQ: begin
                if (mode_req_valid && mode_req_ready) begin
                    mode_req_valid_nxt = 1'b0;
                    state_nxt          = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
